// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator car plant: engine commands, floor
// one-hots, fault codes, half-floor positions and the two FSM state types.
package elevator_pkg;

    localparam logic [1:0] ENG_OFF  = 2'b00;
    localparam logic [1:0] ENG_UP   = 2'b10;
    localparam logic [1:0] ENG_DOWN = 2'b11;

    localparam logic [2:0] FLOOR_NONE = 3'b000;
    localparam logic [2:0] FLOOR_1    = 3'b001;
    localparam logic [2:0] FLOOR_2    = 3'b010;
    localparam logic [2:0] FLOOR_3    = 3'b100;

    localparam logic [1:0] FAULT_NONE       = 2'b00;
    localparam logic [1:0] FAULT_DOOR_CMD   = 2'b01;
    localparam logic [1:0] FAULT_OVERTRAVEL = 2'b10;
    localparam logic [1:0] FAULT_MOVE_DOOR  = 2'b11;

    // Half-floor index: even values sit level with a floor, odd are between.
    localparam logic [2:0] POS_F1 = 3'd0;
    localparam logic [2:0] POS_F2 = 3'd2;
    localparam logic [2:0] POS_F3 = 3'd4;

    typedef enum logic [1:0] {
        MOT_PARKED,
        MOT_MOVE_UP,
        MOT_MOVE_DOWN,
        MOT_FAULT
    } motion_state_t;

    typedef enum logic [1:0] {
        DOOR_CLOSED,
        DOOR_OPENING,
        DOOR_OPEN,
        DOOR_CLOSING
    } door_state_t;

    // One-hot of the floor the car is level with; zero between floors.
    function automatic logic [2:0] floor_onehot(input logic [2:0] pos);
        case (pos)
            POS_F1:  floor_onehot = FLOOR_1;
            POS_F2:  floor_onehot = FLOOR_2;
            POS_F3:  floor_onehot = FLOOR_3;
            default: floor_onehot = FLOOR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/car_door_model.sv
// Car door model: CLOSED/OPENING/OPEN/CLOSING with a travel timer. The
// floor the door opened at is latched so door_open stays tied to it.
module car_door_model
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 4
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        hold,
    input  logic        parked,
    input  logic [2:0]  floor_hot,
    input  logic [2:0]  doors,
    output door_state_t door_state,
    output logic [2:0]  door_open,
    output logic        door_closed
);
    localparam int CW = $clog2(DOOR_CYCLES);

    door_state_t   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    floor_reg;
    logic          cmd_held;
    logic          cnt_done;

    assign cmd_held = |(doors & floor_reg);
    assign cnt_done = (cnt_reg == CW'(DOOR_CYCLES - 1));

    // Door state machine; frozen entirely while hold is asserted.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= DOOR_CLOSED;
            cnt_reg   <= '0;
            floor_reg <= FLOOR_NONE;
        end else if (!hold) begin
            case (state_reg)
                DOOR_CLOSED: begin
                    if (parked && floor_hot != FLOOR_NONE && doors == floor_hot) begin
                        state_reg <= DOOR_OPENING;
                        cnt_reg   <= '0;
                        floor_reg <= floor_hot;
                    end
                end
                DOOR_OPENING: begin
                    if (!cmd_held) begin
                        state_reg <= DOOR_CLOSING;
                        cnt_reg   <= '0;
                    end else if (cnt_done) begin
                        state_reg <= DOOR_OPEN;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (!cmd_held) begin
                        state_reg <= DOOR_CLOSING;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    if (cmd_held) begin
                        state_reg <= DOOR_OPENING;
                        cnt_reg   <= '0;
                    end else if (cnt_done) begin
                        state_reg <= DOOR_CLOSED;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

    assign door_state  = state_reg;
    assign door_open   = (state_reg == DOOR_OPEN) ? floor_reg : FLOOR_NONE;
    assign door_closed = (state_reg == DOOR_CLOSED);

endmodule

// File: rtl/elevator_car_plant.sv
// Elevator car and hoistway plant: integrates engine drive into half-floor
// steps, hosts the door model and latches the first detected fault.
module elevator_car_plant
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] engine,
    input  logic [2:0] doors,
    output logic [2:0] floor_sensor,
    output logic [2:0] position,
    output logic [2:0] door_open,
    output logic       door_closed,
    output logic       fault,
    output logic [1:0] fault_code
);
    localparam int TW = $clog2(TRAVEL_CYCLES);

    motion_state_t motion_reg;
    logic [TW-1:0] travel_cnt_reg;
    logic [2:0]    pos_reg;
    logic          dir_down_reg;
    logic [1:0]    fault_code_reg;

    door_state_t   door_state;
    logic          eng_up, eng_down, eng_drive;
    logic [2:0]    here;
    logic          travel_done, parked, in_fault;
    logic          f_move_door, f_over, f_door_cmd, fault_now;
    logic [1:0]    fault_code_next;

    assign eng_up      = (engine == ENG_UP);
    assign eng_down    = (engine == ENG_DOWN);
    assign eng_drive   = eng_up | eng_down;
    assign here        = floor_onehot(pos_reg);
    assign travel_done = (travel_cnt_reg == TW'(TRAVEL_CYCLES - 1));
    assign parked      = (motion_reg == MOT_PARKED);
    assign in_fault    = (motion_reg == MOT_FAULT);

    // An odd position has no floor one-hot, so any door command mismatches.
    assign f_move_door = eng_drive && (door_state != DOOR_CLOSED);
    assign f_over      = travel_done && ((eng_up && pos_reg == POS_F3) ||
                                         (eng_down && pos_reg == POS_F1));
    assign f_door_cmd  = (doors != FLOOR_NONE) && ((doors != here) || !parked);
    assign fault_now   = !in_fault && (f_move_door || f_over || f_door_cmd);

    // Priority: door-open motion beats overtravel beats bad door command.
    always_comb begin
        fault_code_next = FAULT_DOOR_CMD;
        if (f_move_door)
            fault_code_next = FAULT_MOVE_DOOR;
        else if (f_over)
            fault_code_next = FAULT_OVERTRAVEL;
    end

    // Motion FSM, travel counter, position and fault latch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            motion_reg     <= MOT_PARKED;
            travel_cnt_reg <= '0;
            pos_reg        <= POS_F1;
            dir_down_reg   <= 1'b0;
            fault_code_reg <= FAULT_NONE;
        end else if (!in_fault) begin
            if (fault_now) begin
                motion_reg     <= MOT_FAULT;
                fault_code_reg <= fault_code_next;
            end else if (eng_drive) begin
                motion_reg <= eng_up ? MOT_MOVE_UP : MOT_MOVE_DOWN;
                if (eng_down != dir_down_reg) begin
                    // Direction change restarts the half-floor step.
                    dir_down_reg   <= eng_down;
                    travel_cnt_reg <= '0;
                end else if (travel_done) begin
                    travel_cnt_reg <= '0;
                    pos_reg        <= eng_down ? pos_reg - 3'd1 : pos_reg + 3'd1;
                end else begin
                    travel_cnt_reg <= travel_cnt_reg + TW'(1);
                end
            end else begin
                // Stopping keeps partial travel so a resume continues the step.
                motion_reg <= MOT_PARKED;
            end
        end
    end

    car_door_model #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door (
        .clk        (CLK),
        .srst       (RST),
        .hold       (in_fault | fault_now),
        .parked     (parked),
        .floor_hot  (here),
        .doors      (doors),
        .door_state (door_state),
        .door_open  (door_open),
        .door_closed(door_closed)
    );

    assign position     = pos_reg;
    assign floor_sensor = here;
    assign fault        = in_fault;
    assign fault_code   = fault_code_reg;

endmodule

// File: tb/tb_elevator_car_plant.sv
// Self-checking bench for elevator_car_plant: directed scenarios against
// constants, then randomized traffic against a behavioural model.
module tb_elevator_car_plant;
    import elevator_pkg::*;

    localparam int T = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] engine = 2'b00;
    logic [2:0] doors = 3'b000;
    logic [2:0] floor_sensor, position, door_open;
    logic       door_closed, fault;
    logic [1:0] fault_code;

    int errors = 0;
    int checks = 0;

    // Behavioural model: integer half-floor position, ticks of drive spent
    // on the current step, door phase 0 shut / 1 opening / 2 open / 3 closing.
    int         m_pos, m_ticks, m_dir, m_door, m_dt, m_code;
    bit         m_fault, m_moving;
    logic [2:0] m_dfloor;

    elevator_car_plant #(.TRAVEL_CYCLES(T), .DOOR_CYCLES(D)) dut (
        .CLK(clk), .RST(RST), .engine(engine), .doors(doors),
        .floor_sensor(floor_sensor), .position(position), .door_open(door_open),
        .door_closed(door_closed), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_floor_bits(input int p);
        return (p % 2 == 0) ? 3'(1 << (p / 2)) : 3'b000;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_ticks = 0; m_dir = 1; m_door = 0; m_dt = 0;
        m_code = 0; m_fault = 0; m_moving = 0; m_dfloor = 3'b000;
    endtask

    task automatic model_step(input logic [1:0] e, input logic [2:0] d);
        int dir;
        logic [2:0] fb;
        bit c11, c10, c01, held;
        if (m_fault) return;
        dir = (e == 2'b10) ? 1 : (e == 2'b11) ? -1 : 0;
        fb  = m_floor_bits(m_pos);
        c11 = (dir != 0) && (m_door != 0);
        c10 = (dir != 0) && (m_ticks == T - 1) &&
              ((dir > 0 && m_pos == 4) || (dir < 0 && m_pos == 0));
        c01 = (d != 0) && ((d != fb) || m_moving);
        if (c11 || c10 || c01) begin
            m_fault = 1;
            m_code  = c11 ? 3 : c10 ? 2 : 1;
            return;
        end
        held = (d & m_dfloor) != 0;
        case (m_door)
            0: if (!m_moving && fb != 0 && d == fb) begin m_door = 1; m_dt = 0; m_dfloor = fb; end
            1: if (!held) begin m_door = 3; m_dt = 0; end
               else if (m_dt == D - 1) begin m_door = 2; m_dt = 0; end
               else m_dt++;
            2: if (!held) begin m_door = 3; m_dt = 0; end
            default: if (held) begin m_door = 1; m_dt = 0; end
               else if (m_dt == D - 1) begin m_door = 0; m_dt = 0; end
               else m_dt++;
        endcase
        if (dir != 0) begin
            if (dir != m_dir) begin m_dir = dir; m_ticks = 0; end
            else if (m_ticks == T - 1) begin m_ticks = 0; m_pos += dir; end
            else m_ticks++;
        end
        m_moving = (dir != 0);
    endtask

    // One clock: drive inputs, let the edge happen, advance model, settle.
    task automatic step(input logic r, input logic [1:0] e, input logic [2:0] d);
        RST = r; engine = e; doors = d;
        @(posedge clk);
        if (r) model_reset(); else model_step(e, d);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, ENG_UP, 3'b110);
        checks++; if (position !== 3'd0) begin errors++; $display("FAIL reset_position got=%0d exp=0", position); end
        checks++; if (floor_sensor !== 3'b001) begin errors++; $display("FAIL reset_floor_sensor got=%b exp=001", floor_sensor); end
        checks++; if (door_open !== 3'b000) begin errors++; $display("FAIL reset_door_open got=%b exp=000", door_open); end
        checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL reset_door_closed got=%b exp=1", door_closed); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
        checks++; if (fault_code !== 2'b00) begin errors++; $display("FAIL reset_fault_code got=%b exp=00", fault_code); end
        $display("test_reset done");
    endtask

    task automatic test_travel_up();
        step(1'b1, ENG_OFF, 3'b000);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, ENG_UP, 3'b000);
            if (i == 7) begin
                checks++; if (position !== 3'd0) begin errors++; $display("FAIL travel_pos_before_step got=%0d exp=0", position); end
            end
            if (i == 8) begin
                checks++; if (position !== 3'd1) begin errors++; $display("FAIL travel_pos1 got=%0d exp=1", position); end
                checks++; if (floor_sensor !== 3'b000) begin errors++; $display("FAIL travel_sensor_between got=%b exp=000", floor_sensor); end
            end
        end
        checks++; if (position !== 3'd2) begin errors++; $display("FAIL travel_pos2 got=%0d exp=2", position); end
        checks++; if (floor_sensor !== 3'b010) begin errors++; $display("FAIL travel_sensor_f2 got=%b exp=010", floor_sensor); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL travel_fault got=%b exp=0", fault); end
        $display("test_travel_up done position=%0d", position);
    endtask

    // Continues at F2 from test_travel_up.
    task automatic test_doors();
        step(1'b0, ENG_OFF, 3'b000);
        step(1'b0, ENG_OFF, FLOOR_2);
        checks++; if (door_closed !== 1'b0) begin errors++; $display("FAIL door_closed_fall got=%b exp=0", door_closed); end
        for (int i = 2; i <= D; i++) step(1'b0, ENG_OFF, FLOOR_2);
        checks++; if (door_open !== 3'b000) begin errors++; $display("FAIL door_open_early got=%b exp=000", door_open); end
        step(1'b0, ENG_OFF, FLOOR_2);
        checks++; if (door_open !== 3'b010) begin errors++; $display("FAIL door_open_f2 got=%b exp=010", door_open); end
        for (int i = 1; i <= D; i++) step(1'b0, ENG_OFF, 3'b000);
        checks++; if (door_closed !== 1'b0) begin errors++; $display("FAIL door_closed_early got=%b exp=0", door_closed); end
        step(1'b0, ENG_OFF, 3'b000);
        checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL door_closed_again got=%b exp=1", door_closed); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL door_fault got=%b exp=0", fault); end
        $display("test_doors done");
    endtask

    task automatic test_hold_counter();
        step(1'b1, ENG_OFF, 3'b000);
        for (int i = 0; i < 5; i++) step(1'b0, ENG_UP, 3'b000);
        for (int i = 0; i < 10; i++) step(1'b0, ENG_OFF, 3'b000);
        step(1'b0, ENG_UP, 3'b000);
        step(1'b0, ENG_UP, 3'b000);
        checks++; if (position !== 3'd0) begin errors++; $display("FAIL hold_pos_at7 got=%0d exp=0", position); end
        step(1'b0, ENG_UP, 3'b000);
        checks++; if (position !== 3'd1) begin errors++; $display("FAIL hold_pos_at8 got=%0d exp=1", position); end
        $display("test_hold_counter done position=%0d", position);
    endtask

    task automatic test_overtravel();
        step(1'b1, ENG_OFF, 3'b000);
        for (int i = 0; i < 4 * T; i++) step(1'b0, ENG_UP, 3'b000);
        checks++; if (position !== 3'd4) begin errors++; $display("FAIL over_reach_f3 got=%0d exp=4", position); end
        for (int i = 0; i < T - 1; i++) step(1'b0, ENG_UP, 3'b000);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL over_early got=%b exp=0", fault); end
        step(1'b0, ENG_UP, 3'b000);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL over_fault got=%b exp=1", fault); end
        checks++; if (fault_code !== 2'b10) begin errors++; $display("FAIL over_code got=%b exp=10", fault_code); end
        for (int i = 0; i < 12; i++) step(1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        checks++; if (position !== 3'd4) begin errors++; $display("FAIL over_frozen_pos got=%0d exp=4", position); end
        checks++; if (fault_code !== 2'b10) begin errors++; $display("FAIL over_held_code got=%b exp=10", fault_code); end
        step(1'b1, ENG_DOWN, 3'b001);
        checks++; if (fault !== 1'b0 || position !== 3'd0 || fault_code !== 2'b00) begin
            errors++; $display("FAIL over_reset got=fault%b/pos%0d/code%b exp=fault0/pos0/code00", fault, position, fault_code);
        end
        $display("test_overtravel done");
    endtask

    task automatic test_priority();
        step(1'b1, ENG_OFF, 3'b000);
        for (int i = 0; i <= D; i++) step(1'b0, ENG_OFF, FLOOR_1);
        checks++; if (door_open !== 3'b001) begin errors++; $display("FAIL prio_open_f1 got=%b exp=001", door_open); end
        step(1'b0, ENG_UP, FLOOR_3);
        checks++; if (fault_code !== 2'b11) begin errors++; $display("FAIL prio_code got=%b exp=11", fault_code); end
        checks++; if (door_open !== 3'b001) begin errors++; $display("FAIL prio_door_frozen got=%b exp=001", door_open); end
        step(1'b1, ENG_OFF, 3'b000);
        step(1'b0, ENG_OFF, FLOOR_2);
        checks++; if (fault_code !== 2'b01) begin errors++; $display("FAIL door_cmd_code got=%b exp=01", fault_code); end
        $display("test_priority done");
    endtask

    task automatic test_reset_midtravel();
        step(1'b1, ENG_OFF, 3'b000);
        for (int i = 0; i < 3 * T + 3; i++) step(1'b0, ENG_UP, 3'b000);
        checks++; if (position !== 3'd3) begin errors++; $display("FAIL mid_pos3 got=%0d exp=3", position); end
        step(1'b1, ENG_UP, 3'b000);
        checks++; if (position !== 3'd0 || floor_sensor !== 3'b001 || door_closed !== 1'b1) begin
            errors++; $display("FAIL mid_reset got=pos%0d/fs%b/dc%b exp=pos0/fs001/dc1", position, floor_sensor, door_closed);
        end
        $display("test_reset_midtravel done");
    endtask

    task automatic test_random();
        int mode, left, fault_age;
        logic [1:0] e;
        logic [2:0] d;
        step(1'b1, ENG_OFF, 3'b000);
        mode = 3; left = 0; fault_age = 0;
        for (int n = 0; n < 800; n++) begin
            if (left == 0) begin mode = $urandom_range(0, 9); left = $urandom_range(1, 24); end
            left--;
            e = ENG_OFF; d = 3'b000;
            case (mode)
                0, 1, 2: e = ENG_UP;
                3, 4, 5: e = ENG_DOWN;
                6, 7:    d = m_floor_bits(m_pos);
                8:       e = 2'b01;
                default: begin e = 2'($urandom_range(0, 3)); d = 3'($urandom_range(0, 7)); end
            endcase
            if (m_fault) fault_age++; else fault_age = 0;
            step(fault_age > 3 || $urandom_range(0, 199) == 0, e, d);
            checks++; if (position !== 3'(m_pos)) begin errors++; $display("FAIL rnd_position n=%0d got=%0d exp=%0d", n, position, m_pos); end
            checks++; if (floor_sensor !== m_floor_bits(m_pos)) begin errors++; $display("FAIL rnd_floor_sensor n=%0d got=%b exp=%b", n, floor_sensor, m_floor_bits(m_pos)); end
            checks++; if (door_open !== ((m_door == 2) ? m_dfloor : 3'b000)) begin errors++; $display("FAIL rnd_door_open n=%0d got=%b exp_phase=%0d", n, door_open, m_door); end
            checks++; if (door_closed !== (m_door == 0)) begin errors++; $display("FAIL rnd_door_closed n=%0d got=%b exp_phase=%0d", n, door_closed, m_door); end
            checks++; if (fault !== m_fault) begin errors++; $display("FAIL rnd_fault n=%0d got=%b exp=%b", n, fault, m_fault); end
            checks++; if (fault_code !== 2'(m_code)) begin errors++; $display("FAIL rnd_fault_code n=%0d got=%b exp=%0d", n, fault_code, m_code); end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_travel_up();
        test_doors();
        test_hold_counter();
        test_overtravel();
        test_priority();
        test_reset_midtravel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
